// File: rtl/sysx_slave_endpoint.sv
// sysX v1 peripheral endpoint: oversamples the master bus clock, frames 7-phase words,
// assembles MOSI words into an RX FIFO and serves MISO words from a TX FIFO.

module sysx_slave_endpoint_fifo #(
    parameter int W   = 32,
    parameter int DL2 = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_full
);
    localparam int D = 1 << DL2;

    logic [W-1:0] r_mem [D];
    logic [DL2:0] r_wp, r_rp;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[DL2] != r_rp[DL2]) && (r_wp[DL2-1:0] == r_rp[DL2-1:0]);
    assign o_rdata = r_mem[r_rp[DL2-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wp[DL2-1:0]] <= i_wdata;
    end
endmodule

module sysx_slave_endpoint #(
    parameter logic [1:0]  pSelect     = 2'h0,
    parameter int          pDepthLog2  = 2,
    parameter int          pIdleCycles = 16,
    parameter logic [31:0] pFillWord   = 32'hFFFFFFFF
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iBusClock,
    input  logic [1:0]  iBusSelect,
    input  logic [7:0]  iBusMOSI,
    output logic [7:0]  oBusMISO,
    output logic        oBusDrive,
    output logic        oBusInterrupt,
    output logic [31:0] oRxData,
    output logic        oRxValid,
    input  logic        iRxReady,
    input  logic [31:0] iTxData,
    input  logic        iTxValid,
    output logic        oTxReady,
    output logic [2:0]  oFlags,
    input  logic        iClearFlags
);
    localparam int IW = $clog2(pIdleCycles + 1);

    logic        r_bclk_m, r_bclk_s, r_bclk_d;
    logic [1:0]  r_sel_m, r_sel_s, r_sel_d;
    logic [7:0]  r_mosi_m, r_mosi_s;
    logic [2:0]  r_phase;
    logic [31:0] r_tx, r_rx;
    logic        r_push_pend;
    logic [IW-1:0] r_idle_cnt;
    logic [2:0]  r_flags;

    logic        w_sel, w_fall, w_idle, w_frame_rst, w_step, w_latch, w_data_ph;
    logic [1:0]  w_bidx;
    logic [31:0] w_tx_shift, w_tx_head, w_rx_head;
    logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic [2:0]  w_flag_set;

    assign w_sel       = (r_sel_s == pSelect);
    assign w_fall      = r_bclk_d & ~r_bclk_s;
    assign w_idle      = r_bclk_s && (r_idle_cnt == IW'(pIdleCycles - 1));
    assign w_frame_rst = !w_sel || (r_sel_s != r_sel_d) || w_idle;
    assign w_step      = w_fall && !w_frame_rst;
    assign w_latch     = w_step && (r_phase == 3'd0);
    assign w_data_ph   = (r_phase >= 3'd1) && (r_phase <= 3'd4);
    // Phase 1..4 maps to byte 0..3 (phase 4 wraps to 2'b11).
    assign w_bidx      = 2'(r_phase[1:0] - 2'd1);
    assign w_tx_shift  = r_tx >> {w_bidx, 3'b000};

    assign w_tx_push = iTxValid && !w_tx_full;
    assign w_tx_pop  = w_latch && !w_tx_empty;
    assign w_rx_pop  = !w_rx_empty && iRxReady;
    // A full RX FIFO still accepts when the head pops in the same cycle.
    assign w_rx_push = r_push_pend && (!w_rx_full || w_rx_pop);

    assign w_flag_set = {w_frame_rst && (r_phase != 3'd0),
                         w_latch && w_tx_empty,
                         r_push_pend && !w_rx_push};

    assign oBusDrive     = w_sel;
    assign oBusMISO      = (w_sel && w_data_ph) ? w_tx_shift[7:0] : 8'hFF;
    assign oRxData       = w_rx_head;
    assign oRxValid      = !w_rx_empty;
    assign oBusInterrupt = !w_rx_empty;
    assign oTxReady      = !w_tx_full;
    assign oFlags        = r_flags;

    sysx_slave_endpoint_fifo #(.W(32), .DL2(pDepthLog2)) u_tx_fifo (
        .i_clk(iClock), .i_rst_n(iReset), .i_push(w_tx_push), .i_wdata(iTxData),
        .i_pop(w_tx_pop), .o_rdata(w_tx_head), .o_empty(w_tx_empty), .o_full(w_tx_full)
    );

    sysx_slave_endpoint_fifo #(.W(32), .DL2(pDepthLog2)) u_rx_fifo (
        .i_clk(iClock), .i_rst_n(iReset), .i_push(w_rx_push), .i_wdata(r_rx),
        .i_pop(w_rx_pop), .o_rdata(w_rx_head), .o_empty(w_rx_empty), .o_full(w_rx_full)
    );

    // Synchronizers reset to bus-idle and "not us" so no false edge or select appears.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_bclk_m <= 1'b1;
            r_bclk_s <= 1'b1;
            r_bclk_d <= 1'b1;
            r_sel_m  <= ~pSelect;
            r_sel_s  <= ~pSelect;
            r_sel_d  <= ~pSelect;
            r_mosi_m <= '0;
            r_mosi_s <= '0;
        end else begin
            r_bclk_m <= iBusClock;
            r_bclk_s <= r_bclk_m;
            r_bclk_d <= r_bclk_s;
            r_sel_m  <= iBusSelect;
            r_sel_s  <= r_sel_m;
            r_sel_d  <= r_sel_s;
            r_mosi_m <= iBusMOSI;
            r_mosi_s <= r_mosi_m;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_phase     <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_push_pend <= 1'b0;
            r_idle_cnt  <= '0;
            r_flags     <= '0;
        end else begin
            if (!r_bclk_s)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != IW'(pIdleCycles))
                r_idle_cnt <= r_idle_cnt + 1'b1;

            if (w_frame_rst)
                r_phase <= '0;
            else if (w_step)
                r_phase <= (r_phase == 3'd6) ? 3'd0 : r_phase + 3'd1;

            if (w_latch)
                r_tx <= w_tx_empty ? pFillWord : w_tx_head;
            if (w_step && w_data_ph)
                r_rx[{w_bidx, 3'b000} +: 8] <= r_mosi_s;
            r_push_pend <= w_step && (r_phase == 3'd4);

            r_flags <= (iClearFlags ? 3'b000 : r_flags) | w_flag_set;
        end
    end
endmodule

// File: tb/tb_sysx_slave_endpoint.sv
// Directed bench for sysx_slave_endpoint: bus-master model drives 7-phase words;
// RX words and MISO bytes are checked through scoreboard queues by monitor processes.

module tb_sysx_slave_endpoint;
    localparam int H = 5;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic        iBusClock = 1'b1;
    logic [1:0]  iBusSelect = 2'h0;
    logic [7:0]  iBusMOSI = 8'h00;
    logic [7:0]  oBusMISO;
    logic        oBusDrive, oBusInterrupt, oRxValid, oTxReady;
    logic [31:0] oRxData;
    logic        iRxReady = 1'b0;
    logic [31:0] iTxData = 32'h0;
    logic        iTxValid = 1'b0;
    logic [2:0]  oFlags;
    logic        iClearFlags = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] rx_q[$];
    logic [8:0]  miso_q[$];
    logic        miso_slot = 1'b0;
    logic [8:0]  mon_e;
    logic [31:0] mon_w;

    sysx_slave_endpoint dut (
        .iClock(iClock), .iReset(iReset), .iBusClock(iBusClock), .iBusSelect(iBusSelect),
        .iBusMOSI(iBusMOSI), .oBusMISO(oBusMISO), .oBusDrive(oBusDrive),
        .oBusInterrupt(oBusInterrupt), .oRxData(oRxData), .oRxValid(oRxValid),
        .iRxReady(iRxReady), .iTxData(iTxData), .iTxValid(iTxValid), .oTxReady(oTxReady),
        .oFlags(oFlags), .iClearFlags(iClearFlags)
    );

    always #5 iClock = ~iClock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge iClock);
    endtask

    task automatic clear_flags();
        iClearFlags = 1'b1;
        cycles(1);
        iClearFlags = 1'b0;
        cycles(1);
    endtask

    // Master model: one phase = high half then falling edge then low half.
    task automatic send_word(input logic [31:0] mosi, input int nfalls, input bit txp,
                             input logic [31:0] txw, input logic [31:0] exp_miso,
                             input bit exp_drive);
        for (int p = 0; p < nfalls; p++) begin
            iBusClock = 1'b1;
            iBusMOSI  = (p >= 1 && p <= 4) ? mosi[(p-1)*8 +: 8] : 8'h00;
            if (txp && p == 0) begin
                iTxValid = 1'b1;
                iTxData  = txw;
            end
            cycles(1);
            iTxValid = 1'b0;
            cycles(H - 1);
            if (p >= 1 && p <= 4) begin
                miso_q.push_back({exp_drive, exp_miso[(p-1)*8 +: 8]});
                miso_slot = 1'b1;
            end
            iBusClock = 1'b0;
            cycles(H);
            miso_slot = 1'b0;
        end
    endtask

    // MISO monitor: the master samples at its falling edge.
    always @(negedge iBusClock) begin
        if (miso_slot) begin
            checks++;
            if (miso_q.size() == 0) begin
                errors++;
                $display("FAIL miso_unexpected: got %h expected none", {oBusDrive, oBusMISO});
            end else begin
                mon_e = miso_q.pop_front();
                if ({oBusDrive, oBusMISO} !== mon_e) begin
                    errors++;
                    $display("FAIL miso_byte: got drive=%b byte=%h expected drive=%b byte=%h",
                             oBusDrive, oBusMISO, mon_e[8], mon_e[7:0]);
                end
            end
        end
    end

    // RX monitor: one pop per cycle with valid && ready.
    always @(negedge iClock) begin
        if (iReset && oRxValid && iRxReady) begin
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got %h expected none", oRxData);
            end else begin
                mon_w = rx_q.pop_front();
                if (oRxData !== mon_w) begin
                    errors++;
                    $display("FAIL rx_word: got %h expected %h", oRxData, mon_w);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        cycles(3);
        chk("rst_miso", {24'h0, oBusMISO}, 32'hFF);
        chk("rst_drive", {31'h0, oBusDrive}, 32'h0);
        chk("rst_irq", {31'h0, oBusInterrupt}, 32'h0);
        chk("rst_rxvalid", {31'h0, oRxValid}, 32'h0);
        chk("rst_txready", {31'h0, oTxReady}, 32'h1);
        chk("rst_flags", {29'h0, oFlags}, 32'h0);
        iReset = 1'b1;
        cycles(25);
        chk("drive_selected", {31'h0, oBusDrive}, 32'h1);

        // 1: basic word exchange
        rx_q.push_back(32'h12345678);
        send_word(32'h12345678, 7, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        iBusClock = 1'b1;
        cycles(5);
        chk("t1_irq", {31'h0, oBusInterrupt}, 32'h1);
        chk("t1_flags", {29'h0, oFlags}, 32'h0);
        iRxReady = 1'b1;
        cycles(10);
        chk("t1_drained", {31'h0, oRxValid}, 32'h0);
        cycles(20);

        // 2: TX empty -> fill word, underrun
        rx_q.push_back(32'hA5C3_5A3C);
        send_word(32'hA5C35A3C, 7, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1);
        iBusClock = 1'b1;
        cycles(10);
        chk("t2_flags", {29'h0, oFlags}, 32'h2);
        clear_flags();
        chk("t2_cleared", {29'h0, oFlags}, 32'h0);
        cycles(20);

        // 3: block of 6 words into a 4-deep RX FIFO
        iRxReady = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) rx_q.push_back(32'h1000_0000 + 32'(k) * 32'h0101_0101);
            send_word(32'h1000_0000 + 32'(k) * 32'h0101_0101, 7, 1'b1,
                      32'hC0DE_0000 + 32'(k), 32'hC0DE_0000 + 32'(k), 1'b1);
            chk("t3_txready", {31'h0, oTxReady}, 32'h1);
        end
        iBusClock = 1'b1;
        cycles(10);
        chk("t3_flags", {29'h0, oFlags}, 32'h1);
        chk("t3_irq", {31'h0, oBusInterrupt}, 32'h1);
        clear_flags();
        chk("t3_cleared", {29'h0, oFlags}, 32'h0);
        iRxReady = 1'b1;
        cycles(10);
        chk("t3_drained", {31'h0, oRxValid}, 32'h0);
        cycles(20);

        // 4: different chip select -> endpoint stays off the bus
        iBusSelect = 2'h1;
        cycles(5);
        chk("t4_drive", {31'h0, oBusDrive}, 32'h0);
        send_word(32'h55AA55AA, 7, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0);
        iBusClock = 1'b1;
        cycles(10);
        chk("t4_rxvalid", {31'h0, oRxValid}, 32'h0);
        chk("t4_flags", {29'h0, oFlags}, 32'h0);
        iBusSelect = 2'h0;
        cycles(25);

        // 5: idle timeout after LoLo fall -> abort, then a clean word
        send_word(32'hFFFF0000, 2, 1'b1, 32'h13572468, 32'h13572468, 1'b1);
        iBusClock = 1'b1;
        cycles(24);
        chk("t5_flags", {29'h0, oFlags}, 32'h4);
        clear_flags();
        chk("t5_cleared", {29'h0, oFlags}, 32'h0);
        rx_q.push_back(32'h0F1E2D3C);
        send_word(32'h0F1E2D3C, 7, 1'b1, 32'h2468ACE0, 32'h2468ACE0, 1'b1);
        iBusClock = 1'b1;
        cycles(30);
        chk("t5_flags_after", {29'h0, oFlags}, 32'h0);
        chk("t5_drained", {31'h0, oRxValid}, 32'h0);

        // 6: reset during the Hi byte
        iRxReady = 1'b0;
        rx_q.push_back(32'h76543210);
        send_word(32'h76543210, 7, 1'b1, 32'h0, 32'h0, 1'b1);
        iBusClock = 1'b1;
        cycles(5);
        send_word(32'hCAFEF00D, 3, 1'b1, 32'h11223344, 32'h11223344, 1'b1);
        chk("t6_hi_byte", {24'h0, oBusMISO}, 32'h22);
        iReset = 1'b0;
        #1;
        chk("t6_miso", {24'h0, oBusMISO}, 32'hFF);
        chk("t6_drive", {31'h0, oBusDrive}, 32'h0);
        chk("t6_irq", {31'h0, oBusInterrupt}, 32'h0);
        chk("t6_rxvalid", {31'h0, oRxValid}, 32'h0);
        chk("t6_txready", {31'h0, oTxReady}, 32'h1);
        chk("t6_flags", {29'h0, oFlags}, 32'h0);
        // The pending RX word was wiped by reset.
        void'(rx_q.pop_front());
        iBusClock = 1'b1;
        cycles(5);
        iReset = 1'b1;
        iRxReady = 1'b1;
        cycles(30);
        rx_q.push_back(32'h89ABCDEF);
        send_word(32'h89ABCDEF, 7, 1'b1, 32'h0BADCAFE, 32'h0BADCAFE, 1'b1);
        iBusClock = 1'b1;
        cycles(30);
        chk("t6_flags_after", {29'h0, oFlags}, 32'h0);
        chk("t6_drained", {31'h0, oRxValid}, 32'h0);

        chk("rx_q_empty", rx_q.size(), 32'h0);
        chk("miso_q_empty", miso_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
